// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath units.
//  - CALC_WIDTH : default operand width in bits (results are 2*CALC_WIDTH bits)
//  - OP_ADD/OP_MUL : operator encoding on the 1-bit op input
//  - state_t : sequencing states of the adder/multiplier unit
package calc_pkg;

  localparam int CALC_WIDTH = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/shift_add_mul_core.sv
// Iterative shift-add multiplier datapath.
// Ports:
//  clk, rst_n  : clock, synchronous active-low reset (clears all registers)
//  load        : capture operands, clear accumulator and iteration count
//  step        : perform one shift-add iteration
//  mcand_in    : multiplicand captured on load
//  mplier_in   : multiplier captured on load
//  acc_next    : accumulator value after the iteration taken this cycle
//  last        : the iteration taken this cycle is the final one
module shift_add_mul_core
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               last
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] addend;

  // The multiplicand is kept unshifted; its weight comes from the count,
  // so the partial product for bit cnt is mcand << cnt.
  always_comb begin
    addend   = {{WIDTH{1'b0}}, mcand} << cnt;
    acc_next = mplier[0] ? (acc + addend) : acc;
    last     = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= mcand_in;
      mplier <= mplier_in;
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/adder_multiplier_4bit.sv
// Sequential adder / shift-add multiplier, one operation per start/done.
// Ports:
//  clk, rst_n : clock, synchronous active-low reset
//  start      : request, sampled only in IDLE together with op, a, b
//  op         : OP_ADD (0) or OP_MUL (1)
//  a, b       : operands
//  busy       : operation in progress
//  done       : one-cycle pulse, result valid from this cycle
//  result     : zero-extended sum or product, held until overwritten
//  carry      : carry out of the add; 0 after a multiply
// Handshake: start is a level request honoured only when the unit is IDLE;
// it is neither queued nor re-sampled while busy or during the done cycle.
// Build option: define SIGNED_MUL_EN for two's-complement multiply
// (magnitudes multiplied, product negated on completion). Add stays unsigned.
module adder_multiplier_4bit
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry
);

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH:0]     sum;
  logic               accept;
  logic               mul_load;
  logic               mul_step;
  logic               mul_last;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mul_out;

`ifdef SIGNED_MUL_EN
  logic neg;
`endif

  assign accept   = (state == IDLE) && start;
  assign mul_load = accept && (op == OP_MUL);
  assign mul_step = (state == MUL);

  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q};
`ifdef SIGNED_MUL_EN
    a_mag   = a[WIDTH-1] ? -a : a;
    b_mag   = b[WIDTH-1] ? -b : b;
    mul_out = neg ? -acc_next : acc_next;
`else
    a_mag   = a;
    b_mag   = b;
    mul_out = acc_next;
`endif
  end

  shift_add_mul_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (mul_load),
    .step     (mul_step),
    .mcand_in (a_mag),
    .mplier_in(b_mag),
    .acc_next (acc_next),
    .last     (mul_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
`ifdef SIGNED_MUL_EN
      neg    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            a_q   <= a;
            b_q   <= b;
            busy  <= 1'b1;
            state <= (op == OP_MUL) ? MUL : ADD;
`ifdef SIGNED_MUL_EN
            neg   <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
          end
        end
        ADD: begin
          // result[WIDTH] is the carry bit of the sum by construction.
          result <= {{(WIDTH-1){1'b0}}, sum};
          carry  <= sum[WIDTH];
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        MUL: begin
          if (mul_last) begin
            result <= mul_out;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
